alu_ctrl_decode: RTL and testbench
==================================

// Module: alu_ctrl_decode
// PURPOSE
// Registered decode stage driving the register-to-register ALU control interface.
// - Accepts one 32-bit RV32I instruction per valid/ready handshake.
// - Decodes OP, OP-IMM, LUI and AUIPC into ALU controls (funct3, sub_sra), register indices, immediate and operand selects.
// - Sits between fetch and execute. A 2-entry skid buffer absorbs execute back-pressure without a combinational ready path.
// PARAMETERS
// PC_W         32  width of the PC carried alongside the instruction
// ILLEGAL_NOP  0   0: flag illegal encodings via o_illegal; 1: replace them with ADDI x0,x0,0 and keep o_illegal=0
// PORTS
// i_clk        in   1     clock, all state updates on rising edge
// i_rst        in   1     reset, asynchronous, active-high
// i_flush      in   1     synchronous flush of all buffered entries
// i_valid      in   1     upstream instruction valid
// o_ready      out  1     upstream may transfer (registered)
// i_instr      in   32    instruction word
// i_pc         in   PC_W  instruction address
// o_valid      out  1     decoded entry valid
// i_ready      in   1     execute accepts the decoded entry
// o_funct3     out  3     ALU funct3
// o_sub_sra    out  1     ALU SUB/SRA select
// o_use_imm    out  1     1: ALU operand B = o_imm; 0: operand B = rs2
// o_res_sel    out  2     0 ALU, 1 LUI (result = imm), 2 AUIPC (result = pc + imm)
// o_rs1        out  5     source register 1
// o_rs2        out  5     source register 2
// o_rd         out  5     destination register
// o_wen        out  1     writeback enable, 0 when rd==0 or illegal
// o_imm        out  32    sign-extended I-imm, or U-imm (instr[31:12]<<12)
// o_pc         out  PC_W  PC of the decoded entry
// o_illegal    out  1     unsupported or malformed encoding
// BEHAVIOUR
// - Reset: o_valid=0, all data outputs 0, o_ready=1, skid entry empty.
// - Transfers: input on i_valid&o_ready; output on o_valid&i_ready.
// - Latency: an accepted instruction appears on the outputs on the next edge when the output register is free.
// - Storage: output register (OUT) plus skid register (SKD).
// - Buffer states: EMPTY (o_valid=0), ONE (OUT full), TWO (OUT+SKD full).
//   - EMPTY: accept -> ONE.
//   - ONE: accept & drain -> ONE (new data); accept & stall -> TWO (new data into SKD); drain only -> EMPTY.
//   - TWO: o_ready=0. Drain moves SKD->OUT -> ONE. Stall holds.
// - o_ready is registered as ~(next state == TWO); no combinational path from i_ready to o_ready.
// - Order is preserved. OUT contents are held stable while o_valid&~i_ready.
// - Flush: next state EMPTY. An input accepted in the same cycle is dropped (flush wins). No output transfer is counted.
// - Reset mid-operation: both entries are discarded asynchronously.
// - Decode, by opcode (instr[6:0]):
//   - 0110011 OP: funct3=instr[14:12], sub_sra=instr[30], use_imm=0.
//     Legal only with instr[31:25]=0000000, or 0100000 with funct3 in {000,101}.
//   - 0010011 OP-IMM: use_imm=1, imm = sext(instr[31:20]).
//     sub_sra=instr[30] only when funct3=101; otherwise 0.
//     funct3=001 requires instr[31:25]=0000000. funct3=101 requires 0000000 or 0100000.
//   - 0110111 LUI: res_sel=1. 0010111 AUIPC: res_sel=2, use_imm=1.
//   - Any other opcode, or a violated constraint above: illegal.
// - On illegal: o_wen=0, o_illegal=1. If ILLEGAL_NOP=1: emit ADDI x0,x0,0 fields with o_illegal=0.
// - o_wen = legal & (rd != 0). o_rs2 = instr[24:20] is driven for every opcode.
// TESTING
// - Reset then 0x002081B3 (add x3,x1,x2) -> next cycle o_valid=1, funct3=000, sub_sra=0, rs1=1, rs2=2, rd=3, wen=1.
// - 0x402081B3 (sub) -> sub_sra=1. 0xFFF00093 (addi x1,x0,-1) -> use_imm=1, imm=0xFFFFFFFF, sub_sra=0.
// - 0x40335293 (srai x5,x6,3) -> funct3=101, sub_sra=1, imm[4:0]=3.
//   0x40001093 (slli with bit30 set) -> o_illegal=1, wen=0.
// - 0x12345137 (lui x2) -> res_sel=1, imm=0x12345000, rd=2.
//   AUIPC with pc=0x100 -> res_sel=2, o_pc=0x100.
// - Hold i_ready=0 and stream 3 instructions:
//   - o_ready drops after the 2nd is accepted; OUT stays stable.
//   - Release i_ready: all 3 are delivered in order with no loss or duplication.
// - Reach state TWO, then assert i_flush together with i_valid -> o_valid=0 next cycle, o_ready=1, flushed input never appears.
// - Assert i_rst asynchronously mid-stream -> o_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_ctrl_decode_if.sv
// Fetch/execute handshake bundle for the ALU control decode stage.
// The stage itself binds to the slave modport; whoever drives instructions
// in and consumes decoded entries binds to the master modport.
interface alu_ctrl_decode_if #(
   parameter int PC_W = 32
);
   // upstream (fetch side)
   logic            i_flush;
   logic            i_valid;
   logic            o_ready;
   logic [31:0]     i_instr;
   logic [PC_W-1:0] i_pc;
   // downstream (execute side)
   logic            o_valid;
   logic            i_ready;
   logic [2:0]      o_funct3;
   logic            o_sub_sra;
   logic            o_use_imm;
   logic [1:0]      o_res_sel;
   logic [4:0]      o_rs1;
   logic [4:0]      o_rs2;
   logic [4:0]      o_rd;
   logic            o_wen;
   logic [31:0]     o_imm;
   logic [PC_W-1:0] o_pc;
   logic            o_illegal;
   // debug: occupancy state of the output/skid buffer
   logic [1:0]      o_state;

   modport master (
      output i_flush, i_valid, i_instr, i_pc, i_ready,
      input  o_ready, o_valid, o_funct3, o_sub_sra, o_use_imm, o_res_sel,
             o_rs1, o_rs2, o_rd, o_wen, o_imm, o_pc, o_illegal, o_state
   );

   modport slave (
      input  i_flush, i_valid, i_instr, i_pc, i_ready,
      output o_ready, o_valid, o_funct3, o_sub_sra, o_use_imm, o_res_sel,
             o_rs1, o_rs2, o_rd, o_wen, o_imm, o_pc, o_illegal, o_state
   );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Registered RV32I decode stage (OP, OP-IMM, LUI, AUIPC) feeding the ALU.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a source holds valid and its data stable until that transfer.
// An output register (OUT) plus a skid register (SKD) let o_ready be a plain
// flop, so execute back-pressure never reaches fetch combinationally.
module alu_ctrl_decode #(
   parameter int PC_W        = 32,
   parameter int ILLEGAL_NOP = 0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   alu_ctrl_decode_if.slave  bus
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } buf_state_e;

   typedef struct packed {
      logic [2:0]      funct3;
      logic            sub_sra;
      logic            use_imm;
      logic [1:0]      res_sel;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            wen;
      logic [31:0]     imm;
      logic [PC_W-1:0] pc;
      logic            illegal;
   } entry_t;

   buf_state_e state_q;
   logic       ready_q;
   entry_t     out_q;
   entry_t     skd_q;
   entry_t     dec_d;
   logic       legal_d;

   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       accept;
   logic       drain;

   assign opcode = bus.i_instr[6:0];
   assign f3     = bus.i_instr[14:12];
   assign f7     = bus.i_instr[31:25];
   assign accept = bus.i_valid & ready_q;
   assign drain  = (state_q != S_EMPTY) & bus.i_ready;

   // Decode the incoming word into an entry; illegal words keep their raw
   // fields for diagnosis unless they are to be turned into a NOP.
   always_comb begin
      dec_d         = '0;
      legal_d       = 1'b0;
      dec_d.funct3  = f3;
      dec_d.rs1     = bus.i_instr[19:15];
      dec_d.rs2     = bus.i_instr[24:20];
      dec_d.rd      = bus.i_instr[11:7];
      dec_d.imm     = {{20{bus.i_instr[31]}}, bus.i_instr[31:20]};
      dec_d.pc      = bus.i_pc;
      case (opcode)
         OPC_OP: begin
            dec_d.sub_sra = bus.i_instr[30];
            legal_d = (f7 == F7_BASE) ||
                      ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
         end
         OPC_OP_IMM: begin
            dec_d.use_imm = 1'b1;
            dec_d.sub_sra = (f3 == 3'b101) & bus.i_instr[30];
            case (f3)
               3'b001:  legal_d = (f7 == F7_BASE);
               3'b101:  legal_d = (f7 == F7_BASE) || (f7 == F7_ALT);
               default: legal_d = 1'b1;
            endcase
         end
         OPC_LUI: begin
            legal_d       = 1'b1;
            dec_d.funct3  = 3'b000;
            dec_d.res_sel = 2'd1;
            dec_d.imm     = {bus.i_instr[31:12], 12'h000};
         end
         OPC_AUIPC: begin
            legal_d       = 1'b1;
            dec_d.funct3  = 3'b000;
            dec_d.res_sel = 2'd2;
            dec_d.use_imm = 1'b1;
            dec_d.imm     = {bus.i_instr[31:12], 12'h000};
         end
         default: legal_d = 1'b0;
      endcase
      dec_d.wen     = legal_d & (dec_d.rd != 5'd0);
      dec_d.illegal = ~legal_d;
      if ((ILLEGAL_NOP != 0) && !legal_d) begin
         // ADDI x0,x0,0 carrying the original PC
         dec_d         = '0;
         dec_d.use_imm = 1'b1;
         dec_d.pc      = bus.i_pc;
      end
   end

   // Buffer FSM: moves entries between input, OUT and SKD; o_ready is the
   // registered "next state is not TWO".
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_EMPTY;
         ready_q <= 1'b1;
         out_q   <= '0;
         skd_q   <= '0;
      end else if (bus.i_flush) begin
         state_q <= S_EMPTY;
         ready_q <= 1'b1;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (accept) begin
                  out_q   <= dec_d;
                  state_q <= S_ONE;
               end
            end
            S_ONE: begin
               if (accept && drain) begin
                  out_q   <= dec_d;
               end else if (accept) begin
                  skd_q   <= dec_d;
                  state_q <= S_TWO;
                  ready_q <= 1'b0;
               end else if (drain) begin
                  state_q <= S_EMPTY;
               end
            end
            S_TWO: begin
               if (drain) begin
                  out_q   <= skd_q;
                  state_q <= S_ONE;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= S_EMPTY;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.o_ready   = ready_q;
   assign bus.o_valid   = (state_q != S_EMPTY);
   assign bus.o_state   = state_q;
   assign bus.o_funct3  = out_q.funct3;
   assign bus.o_sub_sra = out_q.sub_sra;
   assign bus.o_use_imm = out_q.use_imm;
   assign bus.o_res_sel = out_q.res_sel;
   assign bus.o_rs1     = out_q.rs1;
   assign bus.o_rs2     = out_q.rs2;
   assign bus.o_rd      = out_q.rd;
   assign bus.o_wen     = out_q.wen;
   assign bus.o_imm     = out_q.imm;
   assign bus.o_pc      = out_q.pc;
   assign bus.o_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// Bench for alu_ctrl_decode: known-encoding table, directed buffer/flush/
// reset sequences, then random traffic against a rule-level decode model
// with an in-order expected queue.
module tb_alu_ctrl_decode;

   typedef struct packed {
      logic [2:0]  funct3;
      logic        sub_sra;
      logic        use_imm;
      logic [1:0]  res_sel;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        wen;
      logic [31:0] imm;
      logic [31:0] pc;
      logic        illegal;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      exp_t        exp;
   } vec_t;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_ctrl_decode_if #(.PC_W(32)) bus ();
   alu_ctrl_decode_if #(.PC_W(32)) bus_nop ();

   alu_ctrl_decode #(.PC_W(32), .ILLEGAL_NOP(0)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   alu_ctrl_decode #(.PC_W(32), .ILLEGAL_NOP(1)) dut_nop (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus_nop)
   );

   assign bus_nop.i_flush = bus.i_flush;
   assign bus_nop.i_valid = bus.i_valid;
   assign bus_nop.i_instr = bus.i_instr;
   assign bus_nop.i_pc    = bus.i_pc;
   assign bus_nop.i_ready = bus.i_ready;

   int   checks = 0;
   int   errors = 0;
   int   delivered = 0;
   exp_t exp_q[$];
   vec_t tbl[10];

   // rule-level reference decode
   function automatic exp_t ref_decode(logic [31:0] ins, logic [31:0] pc, bit nop);
      exp_t             e;
      logic [6:0]       op  = ins[6:0];
      logic [2:0]       f3  = ins[14:12];
      logic [6:0]       f7  = ins[31:25];
      logic signed [11:0] i_imm = ins[31:20];
      logic [19:0]      u_hi = ins[31:12];
      bit is_op    = (op == 7'h33);
      bit is_imm   = (op == 7'h13);
      bit is_lui   = (op == 7'h37);
      bit is_auipc = (op == 7'h17);
      bit is_u     = is_lui || is_auipc;
      bit alt      = (f7 == 7'h20);
      bit base     = (f7 == 7'h00);
      bit legal;
      legal = is_u
           || (is_op  && (base || (alt && (f3 == 3'd0 || f3 == 3'd5))))
           || (is_imm && ((f3 != 3'd1 && f3 != 3'd5) || base || (f3 == 3'd5 && alt)));
      e.funct3  = is_u ? 3'd0 : f3;
      e.sub_sra = (is_op || (is_imm && f3 == 3'd5)) ? ins[30] : 1'b0;
      e.use_imm = is_imm || is_auipc;
      e.res_sel = is_lui ? 2'd1 : (is_auipc ? 2'd2 : 2'd0);
      e.rs1     = ins[19:15];
      e.rs2     = ins[24:20];
      e.rd      = ins[11:7];
      e.imm     = is_u ? 32'(u_hi) * 32'd4096 : 32'(i_imm);
      e.pc      = pc;
      e.wen     = legal && (ins[11:7] != 5'd0);
      e.illegal = !legal;
      if (nop && !legal) begin
         e         = '0;
         e.use_imm = 1'b1;
         e.pc      = pc;
      end
      return e;
   endfunction

   function automatic exp_t mk(logic [2:0] f3, logic sub, logic ui, logic [1:0] rs,
                               logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                               logic wen, logic [31:0] imm, logic [31:0] pc, logic ill);
      exp_t e;
      e.funct3 = f3; e.sub_sra = sub; e.use_imm = ui; e.res_sel = rs;
      e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.wen = wen; e.imm = imm;
      e.pc = pc; e.illegal = ill;
      return e;
   endfunction

   function automatic exp_t nop_of(exp_t e);
      exp_t n;
      if (!e.illegal) return e;
      n         = '0;
      n.use_imm = 1'b1;
      n.pc      = e.pc;
      return n;
   endfunction

   function automatic exp_t act_main();
      return mk(bus.o_funct3, bus.o_sub_sra, bus.o_use_imm, bus.o_res_sel, bus.o_rs1,
                bus.o_rs2, bus.o_rd, bus.o_wen, bus.o_imm, bus.o_pc, bus.o_illegal);
   endfunction

   function automatic exp_t act_nop();
      return mk(bus_nop.o_funct3, bus_nop.o_sub_sra, bus_nop.o_use_imm, bus_nop.o_res_sel,
                bus_nop.o_rs1, bus_nop.o_rs2, bus_nop.o_rd, bus_nop.o_wen, bus_nop.o_imm,
                bus_nop.o_pc, bus_nop.o_illegal);
   endfunction

   task automatic chk_bit(string name, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0b expected=%0b t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_ent(string name, exp_t act, exp_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // One clock: scoreboard checks before the edge, model update after it.
   task automatic tick(output bit acc);
      bit   in_fire, out_fire;
      exp_t e_in;
      chk_bit("o_valid", bus.o_valid, exp_q.size() > 0);
      chk_bit("o_ready", bus.o_ready, exp_q.size() < 2);
      if (bus.o_valid && exp_q.size() > 0) chk_ent("out_entry", act_main(), exp_q[0]);
      in_fire  = bus.i_valid && bus.o_ready && !bus.i_flush;
      out_fire = bus.o_valid && bus.i_ready && !bus.i_flush;
      e_in     = ref_decode(bus.i_instr, bus.i_pc, 1'b0);
      acc      = in_fire || bus.i_flush;
      @(posedge clk);
      #1;
      if (bus.i_flush) begin
         exp_q.delete();
      end else begin
         if (out_fire && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            delivered++;
         end
         if (in_fire) exp_q.push_back(e_in);
      end
   endtask

   task automatic drive_in(logic v, logic [31:0] ins, logic [31:0] pc);
      bus.i_valid = v;
      bus.i_instr = ins;
      bus.i_pc    = pc;
   endtask

   // Present an instruction until it is accepted (bounded).
   task automatic send(logic [31:0] ins, logic [31:0] pc);
      bit acc = 1'b0;
      int n   = 0;
      drive_in(1'b1, ins, pc);
      while (!acc && n < 20) begin
         tick(acc);
         n++;
      end
      if (!acc) begin
         errors++;
         $display("FAIL send_timeout instr=%h not accepted", ins);
      end
      bus.i_valid = 1'b0;
   endtask

   task automatic drain_all();
      bit acc;
      int n = 0;
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      while (exp_q.size() > 0 && n < 20) begin
         tick(acc);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout actual=%0d entries left expected=0", exp_q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      bit          acc;
      logic [31:0] r;
      logic [6:0]  ops[5];
      logic [6:0]  f7;
      bus.i_flush = 1'b0;
      bus.i_ready = 1'b0;
      drive_in(1'b0, 32'h0, 32'h0);

      tbl[0] = '{32'h002081B3, 32'h0000_1000, mk(3'd0, 0, 0, 2'd0, 5'd1, 5'd2,  5'd3,  1, 32'h0000_0002, 32'h0000_1000, 0)};
      tbl[1] = '{32'h402081B3, 32'h0000_1004, mk(3'd0, 1, 0, 2'd0, 5'd1, 5'd2,  5'd3,  1, 32'h0000_0402, 32'h0000_1004, 0)};
      tbl[2] = '{32'hFFF00093, 32'h0000_1008, mk(3'd0, 0, 1, 2'd0, 5'd0, 5'd31, 5'd1,  1, 32'hFFFF_FFFF, 32'h0000_1008, 0)};
      tbl[3] = '{32'h40335293, 32'h0000_100C, mk(3'd5, 1, 1, 2'd0, 5'd6, 5'd3,  5'd5,  1, 32'h0000_0403, 32'h0000_100C, 0)};
      tbl[4] = '{32'h40001093, 32'h0000_1010, mk(3'd1, 0, 1, 2'd0, 5'd0, 5'd0,  5'd1,  0, 32'h0000_0400, 32'h0000_1010, 1)};
      tbl[5] = '{32'h12345137, 32'h0000_1014, mk(3'd0, 0, 0, 2'd1, 5'd8, 5'd3,  5'd2,  1, 32'h1234_5000, 32'h0000_1014, 0)};
      tbl[6] = '{32'h00001517, 32'h0000_0100, mk(3'd0, 0, 1, 2'd2, 5'd0, 5'd0,  5'd10, 1, 32'h0000_1000, 32'h0000_0100, 0)};
      tbl[7] = '{32'h0000007F, 32'h0000_1018, mk(3'd0, 0, 0, 2'd0, 5'd0, 5'd0,  5'd0,  0, 32'h0000_0000, 32'h0000_1018, 1)};
      tbl[8] = '{32'h00208033, 32'h0000_101C, mk(3'd0, 0, 0, 2'd0, 5'd1, 5'd2,  5'd0,  0, 32'h0000_0002, 32'h0000_101C, 0)};
      tbl[9] = '{32'h40209133, 32'h0000_1020, mk(3'd1, 1, 0, 2'd0, 5'd1, 5'd2,  5'd2,  0, 32'h0000_0402, 32'h0000_1020, 1)};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk_bit("rst_o_valid", bus.o_valid, 1'b0);
      chk_bit("rst_o_ready", bus.o_ready, 1'b1);
      chk_ent("rst_data", act_main(), '0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // known encodings, one at a time
      for (int i = 0; i < 10; i++) begin
         bus.i_ready = 1'b0;
         drive_in(1'b1, tbl[i].instr, tbl[i].pc);
         tick(acc);
         bus.i_valid = 1'b0;
         chk_bit($sformatf("tbl%0d_valid", i), bus.o_valid, 1'b1);
         chk_ent($sformatf("tbl%0d_entry", i), act_main(), tbl[i].exp);
         chk_ent($sformatf("tbl%0d_nop", i), act_nop(), nop_of(tbl[i].exp));
         bus.i_ready = 1'b1;
         tick(acc);
      end
      drain_all();

      // stall stream of three: OUT+SKD fill, third waits, all delivered in order
      delivered   = 0;
      bus.i_ready = 1'b0;
      send(32'h002081B3, 32'h200);
      send(32'h402081B3, 32'h204);
      chk_bit("stall_ready_low", bus.o_ready, 1'b0);
      drive_in(1'b1, 32'hFFF00093, 32'h208);
      for (int k = 0; k < 3; k++) begin
         tick(acc);
         chk_bit("stall_no_accept", acc, 1'b0);
      end
      bus.i_ready = 1'b1;
      send(32'hFFF00093, 32'h208);
      drain_all();
      checks++;
      if (delivered != 3) begin
         errors++;
         $display("FAIL stall_delivered actual=%0d expected=3", delivered);
      end

      // flush while full, with a simultaneous input that must be dropped
      bus.i_ready = 1'b0;
      send(32'h00208033, 32'h300);
      send(32'h12345137, 32'h304);
      drive_in(1'b1, 32'h40335293, 32'h308);
      bus.i_flush = 1'b1;
      tick(acc);
      bus.i_flush = 1'b0;
      bus.i_valid = 1'b0;
      chk_bit("flush_valid", bus.o_valid, 1'b0);
      chk_bit("flush_ready", bus.o_ready, 1'b1);
      bus.i_ready = 1'b1;
      repeat (3) tick(acc);

      // asynchronous reset in the middle of a cycle
      bus.i_ready = 1'b0;
      send(32'h00001517, 32'h400);
      drive_in(1'b1, 32'h002081B3, 32'h404);
      #2;
      rst = 1'b1;
      #1;
      chk_bit("arst_valid", bus.o_valid, 1'b0);
      chk_bit("arst_ready", bus.o_ready, 1'b1);
      chk_ent("arst_data", act_main(), '0);
      exp_q.delete();
      bus.i_valid = 1'b0;
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      repeat (2) tick(acc);

      // random traffic against the reference model
      ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h37; ops[3] = 7'h17;
      acc = 1'b1;
      for (int c = 0; c < 800; c++) begin
         if (!bus.i_valid || acc) begin
            r  = $urandom;
            ops[4] = r[6:0];
            case ($urandom_range(0, 2))
               0:       f7 = 7'h00;
               1:       f7 = 7'h20;
               default: f7 = 7'($urandom);
            endcase
            r[31:25] = f7;
            r[6:0]   = ops[$urandom_range(0, 4)];
            drive_in($urandom_range(0, 9) < 7, r, $urandom);
         end
         bus.i_ready = ($urandom_range(0, 9) < 6);
         bus.i_flush = ($urandom_range(0, 39) == 0);
         tick(acc);
      end
      bus.i_flush = 1'b0;
      drain_all();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
